ebi_write_bridge: RTL and testbench
===================================

# ebi_write_bridge

Upstream front end of the register/VRAM write path. Receives asynchronous write cycles from the MCU external bus interface (EBI), synchronizes strobes into `clk`, captures address and data, and decodes each write. Control-space writes become single-cycle strobes on `control_registers` (palette select, state). VRAM-space writes are queued in a small FIFO and drained through a valid/ready port toward the VRAM writer. Write-only: EBI reads are out of scope.

## Interface
Parameters:
- `ADDR_W`, 16: EBI address width; MSB selects control space.
- `DATA_W`, 16: EBI data width; control writes use bits [7:0].
- `FIFO_DEPTH`, 4: VRAM write queue depth, power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ebi_cs_n`  in  1  chip select, active low, asynchronous to `clk`.
- `ebi_we_n`  in  1  write strobe, active low, asynchronous.
- `ebi_addr`  in  ADDR_W  address; stable while `ebi_we_n` low and ≥4 `clk` periods after its rise.
- `ebi_data`  in  DATA_W  write data; same hold rule as `ebi_addr`.
- `ctrl_write_addr`  out  3  control register index (`ebi_addr[2:0]`).
- `ctrl_write_data`  out  8  control register data (`ebi_data[7:0]`).
- `ctrl_write_enable`  out  1  one-cycle write strobe to `control_registers`.
- `vram_addr`  out  ADDR_W-1  FIFO head address (`ebi_addr[ADDR_W-2:0]`).
- `vram_data`  out  DATA_W  FIFO head data.
- `vram_valid`  out  1  FIFO non-empty.
- `vram_ready`  in  1  consumer accepts head when `vram_valid && vram_ready`.
- `overflow`  out  1  sticky: a VRAM write was dropped because the FIFO was full.

## Operation
- `ebi_cs_n`, `ebi_we_n`: two-flop synchronizers plus one history flop for edge detection; all reset to 1 (inactive).
- FSM states: IDLE, ARMED, DISPATCH.
  - IDLE → ARMED: synchronized `we_n` falling edge while synchronized `cs_n` = 0.
  - ARMED → DISPATCH: synchronized `we_n` rising edge with synced `cs_n` = 0; capture `ebi_addr`/`ebi_data` from the pins on this transition.
  - ARMED → IDLE: synced `we_n` rises with synced `cs_n` = 1; write discarded.
  - DISPATCH → IDLE: always, after one cycle.
- Decode in DISPATCH:
  - `addr[ADDR_W-1]` = 1: drive `ctrl_write_addr`/`ctrl_write_data`, pulse `ctrl_write_enable`.
  - `addr[ADDR_W-1]` = 0: push {addr[ADDR_W-2:0], data} into the FIFO.
- FIFO full on push: write dropped, `overflow` set. A pop in the same cycle frees a slot, so the push is accepted with no overflow.
- No bypass: a push into an empty FIFO shows up on `vram_valid` the following cycle.
- `overflow` is cleared only by `reset`.
- A strobe already low when reset releases is treated as a fresh assertion and accepted.
- Reset at any point:
  - FSM returns to IDLE; an in-flight write is discarded.
  - FIFO empties; `overflow` clears.

## Timing
- Reset values: `ctrl_write_enable` = 0, `ctrl_write_addr` = 0, `ctrl_write_data` = 0, `vram_valid` = 0, `vram_addr` = 0, `vram_data` = 0, `overflow` = 0.
- E0 = first `clk` edge sampling `ebi_we_n` high at the pin.
  - Capture happens at E2.
  - `ctrl_write_enable` is high for exactly one cycle, E3→E4.
  - `ctrl_write_addr`/`ctrl_write_data` hold their value until the next control write.
  - A VRAM push commits at E3; `vram_valid` is high from E3 when the FIFO was empty.
- Minimum EBI write cycle: `we_n` low ≥3 `clk` periods, high ≥3 `clk` periods between writes. Shorter pulses are undefined.
- FIFO output is registered from storage; pop takes effect on the clock edge where `vram_valid && vram_ready`.
- Throughput: one VRAM word per cycle.

## Structure
- Package `madnes_bus_pkg`:
  - `bridge_state_t` enum (IDLE, ARMED, DISPATCH).
  - `CTRL_SPACE_BIT`.
  - Control indices: `CTRL_PALETTE_SEL` = 3'b000, `CTRL_STATE` = 3'b001.
  - State encodings: `STATE_NORMAL` = 0, `STATE_LOADING` = 1, `STATE_BOOTSTRAP` = 2.
- Sub-module `sync_fifo`: parameterized width/depth, push/pop/full/empty; reused by the VRAM writer.

## Test plan
- Reset held 3 cycles with pins idle → all outputs 0; `vram_valid` = 0; `overflow` = 0.
- Write addr 0x8001, data 0x0000 → `ctrl_write_enable` high one cycle at E3 with addr 3'b001, data 8'h00; `vram_valid` stays 0.
- Write addr 0x0123, data 0xBEEF with `vram_ready` = 1 → `vram_valid` for one cycle, addr 15'h0123, data 16'hBEEF; no ctrl strobe.
- `vram_ready` = 0, five VRAM writes with data 1..5:
  - Data 1..4 queued; 5 dropped; `overflow` = 1.
  - Then `vram_ready` = 1 → 1, 2, 3, 4 drained in order on consecutive cycles; `overflow` stays 1.
- Write strobe pulsed with `ebi_cs_n` = 1 → no ctrl strobe, no push, FSM returns to IDLE.
- FIFO holding 2 entries, FSM ARMED, `reset` pulsed one cycle:
  - FIFO empty, no strobe when `we_n` rises.
  - Next full write cycle decodes normally.

Source files
------------

// File: rtl/madnes_bus_pkg.sv
// Shared types and constants for the MCU-to-video register/VRAM write path.
package madnes_bus_pkg;

   // Write-cycle tracker: wait for strobe fall, wait for strobe rise, decode.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      DISPATCH = 2'd2
   } bridge_state_t;

   // Address bit selecting control space for the default 16-bit EBI address.
   localparam int CTRL_SPACE_BIT = 15;

   // Control register indices.
   localparam logic [2:0] CTRL_PALETTE_SEL = 3'b000;
   localparam logic [2:0] CTRL_STATE       = 3'b001;

   // Values written to CTRL_STATE.
   localparam logic [7:0] STATE_NORMAL    = 8'd0;
   localparam logic [7:0] STATE_LOADING   = 8'd1;
   localparam logic [7:0] STATE_BOOTSTRAP = 8'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flop storage. The head word comes straight from
// storage (no bypass), so a push into an empty FIFO is visible next cycle.
// A pop and a push in the same cycle are both accepted, even when full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   // Present zero while empty so the head never shows uninitialised storage.
   assign pop_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since empty masks the head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/ebi_write_bridge.sv
// EBI write front end: synchronises the asynchronous strobes, captures each
// write on the strobe's rising edge and routes it either to the control
// register strobe port or into the VRAM write queue.
module ebi_write_bridge
   import madnes_bus_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ebi_cs_n,
   input  logic              ebi_we_n,
   input  logic [ADDR_W-1:0] ebi_addr,
   input  logic [DATA_W-1:0] ebi_data,
   output logic [2:0]        ctrl_write_addr,
   output logic [7:0]        ctrl_write_data,
   output logic              ctrl_write_enable,
   output logic [ADDR_W-2:0] vram_addr,
   output logic [DATA_W-1:0] vram_data,
   output logic              vram_valid,
   input  logic              vram_ready,
   output logic              overflow
);

   localparam int ENTRY_W = ADDR_W - 1 + DATA_W;

   bridge_state_t     state;
   bridge_state_t     state_next;
   logic              cs_meta, cs_sync;
   logic              we_meta, we_sync, we_hist;
   logic              we_fall, we_rise;
   logic              capture, dispatch;
   logic              ctrl_hit, vram_push;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;

   // Two-flop synchronisers plus a history flop on we_n; reset to inactive
   // so a strobe already low at reset release reads as a fresh fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_meta <= 1'b1;
         cs_sync <= 1'b1;
         we_meta <= 1'b1;
         we_sync <= 1'b1;
         we_hist <= 1'b1;
      end else begin
         cs_meta <= ebi_cs_n;
         cs_sync <= cs_meta;
         we_meta <= ebi_we_n;
         we_sync <= we_meta;
         we_hist <= we_sync;
      end
   end

   assign we_fall = !we_sync && we_hist;
   assign we_rise = we_sync && !we_hist;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state logic; a rise with chip select dropped discards the write.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (we_fall && !cs_sync) state_next = ARMED;
         ARMED:    if (we_rise)             state_next = cs_sync ? IDLE : DISPATCH;
         DISPATCH: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // FSM outputs: capture on the accepted rise, decode during DISPATCH.
   always_comb begin
      capture  = 1'b0;
      dispatch = 1'b0;
      case (state)
         ARMED:    capture  = we_rise && !cs_sync;
         DISPATCH: dispatch = 1'b1;
         default:  ;
      endcase
   end

   assign ctrl_hit  = dispatch && addr_q[ADDR_W-1];
   assign vram_push = dispatch && !addr_q[ADDR_W-1];

   // Pin capture; pins are held stable for several clocks after the rise.
   always_ff @(posedge clk) begin
      if (capture) begin
         addr_q <= ebi_addr;
         data_q <= ebi_data;
      end
   end

   // Control strobe pulses one cycle; address/data hold until the next write.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_write_enable <= 1'b0;
         ctrl_write_addr   <= '0;
         ctrl_write_data   <= '0;
      end else begin
         ctrl_write_enable <= ctrl_hit;
         if (ctrl_hit) begin
            ctrl_write_addr <= addr_q[2:0];
            ctrl_write_data <= data_q[7:0];
         end
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_vram_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (vram_push),
      .push_data ({addr_q[ADDR_W-2:0], data_q}),
      .pop       (vram_ready),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign vram_valid = !fifo_empty;
   assign vram_addr  = fifo_head[ENTRY_W-1:DATA_W];
   assign vram_data  = fifo_head[DATA_W-1:0];

   // Sticky drop flag; a same-cycle pop makes room so that push is not a drop.
   always_ff @(posedge clk) begin
      if (reset) overflow <= 1'b0;
      else if (vram_push && fifo_full && !(vram_valid && vram_ready)) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_ebi_write_bridge.sv
// Directed bench for ebi_write_bridge: control writes, VRAM queueing,
// overflow, discarded cycles and reset during an in-flight write.
module tb_ebi_write_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        ebi_cs_n, ebi_we_n;
   logic [15:0] ebi_addr, ebi_data;
   logic [2:0]  ctrl_write_addr;
   logic [7:0]  ctrl_write_data;
   logic        ctrl_write_enable;
   logic [14:0] vram_addr;
   logic [15:0] vram_data;
   logic        vram_valid, vram_ready, overflow;

   int n_assert = 0;
   int n_fail   = 0;

   // Per-cycle samples after E0..E7 of the last write cycle.
   logic        en_s  [8];
   logic        val_s [8];
   logic [2:0]  ca_s  [8];
   logic [7:0]  cd_s  [8];
   logic [14:0] va_s  [8];
   logic [15:0] vd_s  [8];

   always #5 clk = ~clk;

   ebi_write_bridge #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .ebi_cs_n          (ebi_cs_n),
      .ebi_we_n          (ebi_we_n),
      .ebi_addr          (ebi_addr),
      .ebi_data          (ebi_data),
      .ctrl_write_addr   (ctrl_write_addr),
      .ctrl_write_data   (ctrl_write_data),
      .ctrl_write_enable (ctrl_write_enable),
      .vram_addr         (vram_addr),
      .vram_data         (vram_data),
      .vram_valid        (vram_valid),
      .vram_ready        (vram_ready),
      .overflow          (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One EBI write: we_n low 5 clocks, chip select may change before the
   // rise, then 8 samples starting after E0, then an idle gap.
   task automatic ebi_write(input logic [15:0] a, input logic [15:0] d,
                            input logic cs_fall, input logic cs_rise);
      ebi_addr = a;
      ebi_data = d;
      ebi_cs_n = cs_fall;
      ebi_we_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 ebi_cs_n = cs_rise;
      @(posedge clk);
      #1 ebi_we_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         en_s[k]  = ctrl_write_enable;
         val_s[k] = vram_valid;
         ca_s[k]  = ctrl_write_addr;
         cd_s[k]  = ctrl_write_data;
         va_s[k]  = vram_addr;
         vd_s[k]  = vram_data;
      end
      ebi_cs_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      ebi_cs_n   = 1'b1;
      ebi_we_n   = 1'b1;
      ebi_addr   = 16'h0000;
      ebi_data   = 16'h0000;
      vram_ready = 1'b0;

      // Reset held 3 cycles with pins idle.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en",    ctrl_write_enable, 0);
      chk("rst_caddr", ctrl_write_addr,   0);
      chk("rst_cdata", ctrl_write_data,   0);
      chk("rst_valid", vram_valid,        0);
      chk("rst_vaddr", vram_addr,         0);
      chk("rst_vdata", vram_data,         0);
      chk("rst_ovf",   overflow,          0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Control write 0x8001 / 0x0000: strobe only at E3.
      ebi_write(16'h8001, 16'h0000, 1'b0, 1'b0);
      chk("c1_en_e2",  en_s[2], 0);
      chk("c1_en_e3",  en_s[3], 1);
      chk("c1_en_e4",  en_s[4], 0);
      chk("c1_addr",   ca_s[3], 3'b001);
      chk("c1_data",   cd_s[3], 8'h00);
      chk("c1_valid",  val_s[3] | val_s[4] | val_s[7], 0);

      // Control write 0x8005 / 0x12A5: only the low byte lands.
      ebi_write(16'h8005, 16'h12A5, 1'b0, 1'b0);
      chk("c2_en_e3",  en_s[3], 1);
      chk("c2_addr",   ca_s[3], 3'b101);
      chk("c2_data",   cd_s[3], 8'hA5);
      chk("c2_hold",   cd_s[7], 8'hA5);

      // VRAM write 0x0123 / 0xBEEF with consumer ready: one-cycle valid.
      vram_ready = 1'b1;
      ebi_write(16'h0123, 16'hBEEF, 1'b0, 1'b0);
      chk("v1_val_e2", val_s[2], 0);
      chk("v1_val_e3", val_s[3], 1);
      chk("v1_val_e4", val_s[4], 0);
      chk("v1_addr",   va_s[3], 15'h0123);
      chk("v1_data",   vd_s[3], 16'hBEEF);
      chk("v1_no_en",  en_s[3] | en_s[4], 0);
      chk("v1_chold",  ca_s[7], 3'b101);

      // Five VRAM writes with consumer stalled: fifth one dropped.
      vram_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         ebi_write(16'h0010 + 16'(i), 16'(i), 1'b0, 1'b0);
      end
      chk("q_ovf_4",   overflow,   0);
      chk("q_valid",   vram_valid, 1);
      ebi_write(16'h0015, 16'h0005, 1'b0, 1'b0);
      chk("q_ovf_5",   overflow,   1);
      chk("q_head",    vram_data,  16'h0001);
      chk("q_head_a",  vram_addr,  15'h0011);

      // Drain on consecutive cycles.
      vram_ready = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         @(posedge clk);
         #1;
         chk("drain_data", vram_data,  16'(i));
         chk("drain_addr", vram_addr,  15'h0010 + 15'(i));
         chk("drain_val",  vram_valid, 1);
      end
      @(posedge clk);
      #1;
      chk("drain_empty", vram_valid, 0);
      chk("drain_ovf",   overflow,   1);

      // Strobe pulsed with chip select inactive throughout.
      ebi_write(16'h8006, 16'h0033, 1'b1, 1'b1);
      chk("cs1_no_en",  en_s[3] | en_s[4] | en_s[5], 0);
      chk("cs1_no_val", val_s[3] | val_s[4] | val_s[5], 0);
      chk("cs1_chold",  ca_s[7], 3'b101);

      // Chip select drops away before the rise: write discarded from ARMED.
      ebi_write(16'h8007, 16'h0044, 1'b0, 1'b1);
      chk("cs2_no_en",  en_s[3] | en_s[4] | en_s[5], 0);
      chk("cs2_chold",  cd_s[7], 8'hA5);

      // Next write after the discards decodes normally.
      ebi_write(16'h8000, 16'h0002, 1'b0, 1'b0);
      chk("c3_en_e3",  en_s[3], 1);
      chk("c3_addr",   ca_s[3], 3'b000);
      chk("c3_data",   cd_s[3], 8'h02);

      // Two entries queued, then a control write armed and reset pulsed.
      vram_ready = 1'b0;
      ebi_write(16'h0040, 16'h1111, 1'b0, 1'b0);
      ebi_write(16'h0041, 16'h2222, 1'b0, 1'b0);
      chk("r_pre_val", vram_valid, 1);
      ebi_addr = 16'h8003;
      ebi_data = 16'h0055;
      ebi_cs_n = 1'b0;
      ebi_we_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      ebi_we_n = 1'b1;
      chk("r_val",   vram_valid,      0);
      chk("r_ovf",   overflow,        0);
      chk("r_caddr", ctrl_write_addr, 0);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         chk("r_no_en",  ctrl_write_enable, 0);
         chk("r_no_val", vram_valid,        0);
      end
      ebi_cs_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Full write cycle after reset decodes normally.
      ebi_write(16'h8002, 16'h0077, 1'b0, 1'b0);
      chk("c4_en_e3", en_s[3], 1);
      chk("c4_en_e4", en_s[4], 0);
      chk("c4_addr",  ca_s[3], 3'b010);
      chk("c4_data",  cd_s[3], 8'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
